// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared status encodings, iop bit positions and defaults for the station array
package core_pkg;

    typedef enum logic [2:0] {
        ST_FREE   = 3'b000,
        ST_WAIT_1 = 3'b001,
        ST_WAIT_2 = 3'b010,
        ST_WAIT_3 = 3'b011,
        ST_LOAD_0 = 3'b100,
        ST_LOAD_1 = 3'b101,
        ST_ALU    = 3'b110,
        ST_STORE  = 3'b111
    } status_t;

    localparam int IOP_WB_BIT    = 28;
    localparam int IOP_JSR_BIT   = 23;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_IOP_W = 32;

    // Status an issuable entry moves to when the scheduler accepts it.
    function automatic status_t ack_next(status_t s, logic wb, logic jsr);
        case (s)
            ST_LOAD_0: ack_next = ST_WAIT_1;
            ST_LOAD_1: ack_next = wb ? ST_FREE : ST_WAIT_2;
            ST_ALU:    ack_next = jsr ? ST_STORE : ST_FREE;
            ST_STORE:  ack_next = ST_FREE;
            default:   ack_next = s;
        endcase
    endfunction

endpackage

// File: rtl/station_array_if.sv
// rtl/station_array_if.sv - decode, load-writeback and scheduler signals of the station array
interface station_array_if #(
    parameter int DEPTH = core_pkg::DEFAULT_DEPTH,
    parameter int IOP_W = core_pkg::DEFAULT_IOP_W
);
    localparam int TAG_W = $clog2(DEPTH);

    logic             flush;
    logic             id_feed;
    logic [IOP_W-1:0] id_iop;
    logic [2:0]       id_iop_init;
    logic [15:0]      id_pc;
    logic [15:0]      id_k16;
    logic             id_ready;
    logic [TAG_W-1:0] id_tag;
    logic             lsu_wb;
    logic [TAG_W-1:0] lsu_tag;
    logic [15:0]      lsu_data;
    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [2:0]       r_status;
    logic [IOP_W-1:0] r_iop;
    logic [15:0]      r_pc;
    logic [15:0]      r_k16;
    logic             r_will_complete;
    logic             sched_ack;
    logic [TAG_W:0]   occupancy;

    modport master (
        output flush, id_feed, id_iop, id_iop_init, id_pc, id_k16,
               lsu_wb, lsu_tag, lsu_data, sched_ack,
        input  id_ready, id_tag, r_valid, r_tag, r_status, r_iop, r_pc, r_k16,
               r_will_complete, occupancy
    );

    modport slave (
        input  flush, id_feed, id_iop, id_iop_init, id_pc, id_k16,
               lsu_wb, lsu_tag, lsu_data, sched_ack,
        output id_ready, id_tag, r_valid, r_tag, r_status, r_iop, r_pc, r_k16,
               r_will_complete, occupancy
    );
endinterface

// File: rtl/station_entry.sv
// rtl/station_entry.sv - one reservation entry: status FSM plus iop/pc/k16 registers
module station_entry
    import core_pkg::*;
#(
    parameter int IOP_W = DEFAULT_IOP_W
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [2:0]       init,
    input  logic [IOP_W-1:0] iop_in,
    input  logic [15:0]      pc_in,
    input  logic [15:0]      k16_in,
    input  logic             wb,
    input  logic [15:0]      wb_data,
    input  logic             ack,
    output status_t          status,
    output logic [IOP_W-1:0] iop,
    output logic [15:0]      pc,
    output logic [15:0]      k16
);
    status_t next_status;

    always_ff @(posedge clk) begin
        if (a_rst || flush)
            status <= ST_FREE;
        else
            status <= next_status;
    end

    // Allocation only ever targets a FREE entry, so it cannot collide with a wait/ack transition.
    always_comb begin
        next_status = status;
        if (alloc) begin
            next_status = status_t'(init);
        end else begin
            case (status)
                ST_WAIT_1: if (wb) next_status = ST_LOAD_1;
                ST_WAIT_2: if (wb) next_status = ST_ALU;
                ST_WAIT_3: next_status = ST_STORE;
                default:   if (ack) next_status = ack_next(status, iop[IOP_WB_BIT], iop[IOP_JSR_BIT]);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            iop <= '0;
            pc  <= '0;
            k16 <= '0;
        end else if (!flush) begin
            if (alloc) begin
                iop <= iop_in;
                pc  <= pc_in;
                k16 <= k16_in;
            end else if (wb && status != ST_FREE) begin
                k16 <= wb_data;
            end
        end
    end
endmodule

// File: rtl/station_array.sv
// rtl/station_array.sv - reservation station: free-slot allocation, age matrix and oldest-ready selection
module station_array
    import core_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  IOP_W = DEFAULT_IOP_W,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            a_rst,
    station_array_if.slave  bus
);
    status_t          st     [DEPTH];
    logic [IOP_W-1:0] iop_q  [DEPTH];
    logic [15:0]      pc_q   [DEPTH];
    logic [15:0]      k16_q  [DEPTH];
    // older[i][j] = 1 when entry i was allocated before entry j
    logic [DEPTH-1:0] older  [DEPTH];
    logic [DEPTH-1:0] ready;
    logic             free_any;
    logic [TAG_W-1:0] free_tag;
    logic             sel_valid;
    logic [TAG_W-1:0] sel_tag;
    logic [TAG_W:0]   occ;
    logic             do_alloc;

    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        occ      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = st[i][2];
            if (st[i] == ST_FREE) begin
                free_any = 1'b1;
                free_tag = TAG_W'(i);
            end else begin
                occ = occ + (TAG_W + 1)'(1);
            end
        end
    end

    // An entry is oldest-ready when no other ready entry is older than it.
    always_comb begin
        sel_valid = 1'b0;
        sel_tag   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i] && ((ready & ~older[i] & ~(DEPTH'(1) << i)) == '0)) begin
                sel_valid = 1'b1;
                sel_tag   = TAG_W'(i);
            end
        end
    end

    assign do_alloc = bus.id_feed && free_any;

    always_ff @(posedge clk) begin
        if (a_rst || bus.flush) begin
            for (int i = 0; i < DEPTH; i++)
                older[i] <= '0;
        end else if (do_alloc) begin
            for (int j = 0; j < DEPTH; j++) begin
                older[free_tag][j] <= 1'b0;
                if (TAG_W'(j) != free_tag)
                    older[j][free_tag] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        station_entry #(.IOP_W(IOP_W)) u_entry (
            .clk     (clk),
            .a_rst   (a_rst),
            .flush   (bus.flush),
            .alloc   (do_alloc && free_tag == TAG_W'(g)),
            .init    (bus.id_iop_init),
            .iop_in  (bus.id_iop),
            .pc_in   (bus.id_pc),
            .k16_in  (bus.id_k16),
            .wb      (bus.lsu_wb && bus.lsu_tag == TAG_W'(g)),
            .wb_data (bus.lsu_data),
            .ack     (bus.sched_ack && sel_valid && sel_tag == TAG_W'(g)),
            .status  (st[g]),
            .iop     (iop_q[g]),
            .pc      (pc_q[g]),
            .k16     (k16_q[g])
        );
    end

    assign bus.id_ready        = free_any;
    assign bus.id_tag          = free_tag;
    assign bus.r_valid         = sel_valid;
    assign bus.r_tag           = sel_tag;
    assign bus.r_status        = st[sel_tag];
    assign bus.r_iop           = iop_q[sel_tag];
    assign bus.r_pc            = pc_q[sel_tag];
    assign bus.r_k16           = k16_q[sel_tag];
    assign bus.r_will_complete = sel_valid &&
        (ack_next(st[sel_tag], iop_q[sel_tag][IOP_WB_BIT], iop_q[sel_tag][IOP_JSR_BIT]) == ST_FREE);
    assign bus.occupancy       = occ;
endmodule

// File: tb/tb_station_array.sv
// tb/tb_station_array.sv - scoreboard bench for station_array with directed vectors
module tb_station_array;
    localparam int F_RV = 0, F_RT = 1, F_RS = 2, F_K16 = 3, F_OCC = 4, F_IDR = 5, F_IDT = 6, F_WC = 7;

    typedef struct {
        string name;
        int    cyc;
        int    field;
        int    value;
    } exp_t;

    logic clk = 1'b0;
    logic a_rst = 1'b1;
    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   act;

    station_array_if #(.DEPTH(4), .IOP_W(32)) bus ();

    station_array #(.DEPTH(4), .IOP_W(32)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int actual(int f);
        case (f)
            F_RV:    return int'(bus.r_valid);
            F_RT:    return int'(bus.r_tag);
            F_RS:    return int'(bus.r_status);
            F_K16:   return int'(bus.r_k16);
            F_OCC:   return int'(bus.occupancy);
            F_IDR:   return int'(bus.id_ready);
            F_IDT:   return int'(bus.id_tag);
            default: return int'(bus.r_will_complete);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc == ncyc) begin
            me = q.pop_front();
            act = actual(me.field);
            checks++;
            if (act != me.value) begin
                failures++;
                $display("FAIL %s: got 0x%0h want 0x%0h", me.name, act, me.value);
            end
        end
        ncyc++;
    end

    task automatic want(string n, int f, int v);
        exp_t e;
        e.name = n;
        e.cyc = ncyc;
        e.field = f;
        e.value = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.id_feed = 1'b0;
        bus.sched_ack = 1'b0;
        bus.lsu_wb = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic feed(logic [2:0] init, logic [31:0] iop, logic [15:0] k);
        bus.id_feed = 1'b1;
        bus.id_iop_init = init;
        bus.id_iop = iop;
        bus.id_pc = 16'h0100;
        bus.id_k16 = k;
        tick();
    endtask

    task automatic ack();
        bus.sched_ack = 1'b1;
        tick();
    endtask

    task automatic wb(logic [1:0] t, logic [15:0] d);
        bus.lsu_wb = 1'b1;
        bus.lsu_tag = t;
        bus.lsu_data = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 0; bus.id_feed = 0; bus.id_iop = 0; bus.id_iop_init = 0;
        bus.id_pc = 0; bus.id_k16 = 0; bus.lsu_wb = 0; bus.lsu_tag = 0;
        bus.lsu_data = 0; bus.sched_ack = 0;
        tick();
        tick();
        a_rst = 1'b0;
        want("rst_idr", F_IDR, 1); want("rst_idt", F_IDT, 0); want("rst_rv", F_RV, 0);
        want("rst_rt", F_RT, 0); want("rst_occ", F_OCC, 0);

        for (int i = 0; i < 4; i++) begin
            want("fill_idt", F_IDT, i);
            feed(3'b110, 32'h0, 16'(i));
        end
        want("full_idr", F_IDR, 0); want("full_occ", F_OCC, 4); want("full_rv", F_RV, 1);
        want("full_rt", F_RT, 0); want("full_rs", F_RS, 6); want("full_wc", F_WC, 1);
        feed(3'b100, 32'h0, 16'h0);
        want("overfeed_occ", F_OCC, 4); want("overfeed_idr", F_IDR, 0);

        bus.flush = 1'b1; bus.id_feed = 1'b1; bus.sched_ack = 1'b1;
        tick();
        want("flush_occ", F_OCC, 0); want("flush_idr", F_IDR, 1); want("flush_rv", F_RV, 0);

        feed(3'b100, 32'h0, 16'h0001);
        feed(3'b110, 32'h0, 16'h0002);
        want("age_rt", F_RT, 0); want("age_rs", F_RS, 4); want("load0_wc", F_WC, 0);
        ack();
        want("ack_a_rt", F_RT, 1); want("ack_a_rs", F_RS, 6); want("ack_a_occ", F_OCC, 2);
        wb(2'd0, 16'h1234);
        want("wb_rt", F_RT, 0); want("wb_rs", F_RS, 5); want("wb_k16", F_K16, 16'h1234);
        want("load1_wc", F_WC, 0);
        wb(2'd3, 16'hFFFF);
        want("wbfree_rt", F_RT, 0); want("wbfree_occ", F_OCC, 2);
        want("wbfree_k16", F_K16, 16'h1234); want("wbfree_idt", F_IDT, 2);
        bus.sched_ack = 1'b1;
        wb(2'd1, 16'h5555);
        want("both_rt", F_RT, 1); want("both_k16", F_K16, 16'h5555); want("both_rs", F_RS, 6);
        wb(2'd0, 16'h0042);
        want("wait2_rt", F_RT, 0); want("wait2_rs", F_RS, 6); want("wait2_k16", F_K16, 16'h0042);
        ack();
        want("drain1_occ", F_OCC, 1); want("drain1_rt", F_RT, 1);
        ack();
        want("drain2_occ", F_OCC, 0); want("drain2_rv", F_RV, 0);

        feed(3'b110, 32'h0080_0000, 16'h0);
        want("jsr_wc", F_WC, 0); want("jsr_rs", F_RS, 6); want("jsr_rt", F_RT, 0);
        ack();
        want("store_rs", F_RS, 7); want("store_wc", F_WC, 1); want("store_occ", F_OCC, 1);
        ack();
        want("jsrdone_occ", F_OCC, 0); want("jsrdone_rv", F_RV, 0);
        feed(3'b011, 32'h0, 16'h0);
        want("wait3_rv", F_RV, 0); want("wait3_occ", F_OCC, 1);
        tick();
        want("w3st_rv", F_RV, 1); want("w3st_rs", F_RS, 7);
        ack();
        want("w3done_occ", F_OCC, 0);
        feed(3'b000, 32'h0, 16'h0);
        want("init0_occ", F_OCC, 0); want("init0_idt", F_IDT, 0);
        feed(3'b101, 32'h1000_0000, 16'h0);
        want("l1wb_rs", F_RS, 5); want("l1wb_wc", F_WC, 1);
        ack();
        want("l1wb_occ", F_OCC, 0);

        feed(3'b001, 32'h0, 16'h0);
        feed(3'b110, 32'h0, 16'h0);
        feed(3'b110, 32'h0, 16'h0);
        want("reuse_rt0", F_RT, 1); want("reuse_idt0", F_IDT, 3);
        bus.sched_ack = 1'b1;
        feed(3'b110, 32'h0, 16'h0);
        want("reuse_occ", F_OCC, 3); want("reuse_idt", F_IDT, 1); want("reuse_rt", F_RT, 2);
        feed(3'b110, 32'h0, 16'h0);
        want("reuse_full_occ", F_OCC, 4); want("reuse_full_idr", F_IDR, 0);
        ack();
        want("order_w_rt", F_RT, 3);
        ack();
        want("order_v_rt", F_RT, 1);

        a_rst = 1'b1;
        bus.id_feed = 1'b1; bus.id_iop_init = 3'b110; bus.lsu_wb = 1'b1; bus.lsu_tag = 2'd0;
        tick();
        a_rst = 1'b0;
        want("midrst_occ", F_OCC, 0); want("midrst_idr", F_IDR, 1);
        want("midrst_rv", F_RV, 0); want("midrst_rt", F_RT, 0);

        repeat (3) tick();
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/station_array.md
STATION_ARRAY -- requirements
Module: station_array

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; legal range 2..8.
REQ-002 Parameter IOP_W, default 32, internal-operation word width.
REQ-003 Parameter TAG_W, default $clog2(DEPTH), entry tag width; derived, not overridden.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 a_rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard all entries.
REQ-007 id_feed  in  1  allocate request.
REQ-008 id_iop  in  IOP_W  operation word.
REQ-009 id_iop_init  in  3  initial entry status.
REQ-010 id_pc, id_k16  in  16 each  PC and constant.
REQ-011 id_ready  out  1  at least one free entry.
REQ-012 id_tag  out  TAG_W  entry that id_feed fills this cycle.
REQ-013 lsu_wb  in  1  load data valid.
REQ-014 lsu_tag  in  TAG_W  target entry of lsu_wb.
REQ-015 lsu_data  in  16  load data.
REQ-016 r_valid  out  1  selected entry is issuable.
REQ-017 r_tag  out  TAG_W  selected entry.
REQ-018 r_status  out  3  selected entry status.
REQ-019 r_iop, r_pc, r_k16  out  IOP_W/16/16  selected entry fields.
REQ-020 r_will_complete  out  1  selected entry goes free on sched_ack.
REQ-021 sched_ack  in  1  scheduler accepted selected entry this cycle.
REQ-022 occupancy  out  TAG_W+1  count of non-free entries.

Function
REQ-023 Per-entry 3-bit status: 000 FREE, 001 WAIT_1, 010 WAIT_2, 011 WAIT_3, 100 LOAD_0, 101 LOAD_1, 110 ALU, 111 STORE; status[2]=1 means ready.
REQ-024 id_tag SHALL be the lowest-index FREE entry; id_ready=0 when all entries are non-FREE.
REQ-025 id_feed with id_ready=1 SHALL write iop, pc, k16, status=id_iop_init into entry id_tag; id_feed with id_ready=0 is ignored.
REQ-026 id_iop_init=000 on allocation SHALL leave the entry FREE.
REQ-027 WAIT_1 -> LOAD_1 and WAIT_2 -> ALU only on lsu_wb with lsu_tag equal to the entry; otherwise hold.
REQ-028 WAIT_3 -> STORE unconditionally next cycle.
REQ-029 On sched_ack, the selected entry transitions: LOAD_0->WAIT_1; LOAD_1->WAIT_2 if iop[28]=0, else FREE; ALU->STORE if iop[23]=1, else FREE; STORE->FREE. Non-selected ready entries hold.
REQ-030 lsu_wb to a non-FREE entry SHALL load lsu_data into that entry's k16 next cycle, in any state; lsu_wb to a FREE entry is ignored.
REQ-031 Age matrix: on allocation of k, k becomes younger than every non-FREE entry.
REQ-032 Selection: the oldest ready entry; r_valid=0 and r_tag=0 when none is ready.
REQ-033 r_will_complete=1 iff the selected entry's sched_ack transition targets FREE.
REQ-034 Selection, r_* outputs, id_ready and id_tag are combinational from current state, with zero-cycle latency.
REQ-035 sched_ack with r_valid=0 is ignored.
REQ-036 flush SHALL set all entries FREE next cycle; it overrides id_feed, lsu_wb and sched_ack in the same cycle.
REQ-037 Simultaneous sched_ack freeing entry j and id_feed: allocation uses the pre-cycle id_tag, and j is reusable the following cycle.
REQ-038 Simultaneous lsu_wb and sched_ack on different entries SHALL both take effect.

Reset
REQ-039 a_rst SHALL set every entry FREE and clear the age matrix; outputs then read id_ready=1, id_tag=0, r_valid=0, r_tag=0, occupancy=0.
REQ-040 a_rst mid-operation discards all entries, and all inputs are ignored while it is asserted.

Structure
REQ-041 Status encodings, IOP bit positions (28 write-back, 23 jsr), and default DEPTH/IOP_W SHALL live in shared package core_pkg.
REQ-042 One sub-module, station_entry: per-entry status FSM and field registers, instantiated DEPTH times; selection and the age matrix stay in station_array.

Verification
REQ-043 Reset, then feed init=110, iop[23]=0, into all 4 entries -> tags 0,1,2,3; id_ready=0 after the 4th; occupancy=4.
REQ-044 Feed A(tag0, init 100), then B(tag1, init 110); ack B? No: r_tag=0 first; ack -> A is WAIT_1 and r_tag=1.
REQ-045 A in WAIT_1; lsu_wb tag0 with data 0x1234 -> next cycle A is LOAD_1 and r_k16=0x1234; lsu_wb tag3 (FREE) causes no change.
REQ-046 Entry in ALU with iop[23]=1: r_will_complete=0; ack -> STORE, r_will_complete=1; ack -> FREE, occupancy decreases by 1.
REQ-047 Full array; flush together with id_feed and sched_ack -> next cycle occupancy=0, id_ready=1, r_valid=0.
REQ-048 Free tag1 via ack in the same cycle id_feed fills the pre-cycle id_tag -> the next feed receives tag1, and age order places it youngest.
